btu_top: RTL and testbench

//  Bit-transpose unit. Accepts NUM_WORDS packed words, each holding 4 (n<=8) or 2 (n>=9)
//  n-bit values, and emits bit-plane rows: row r = bit r of one value slot across all

---
 rtl/btu_pkg.sv | 39 +++
 rtl/btu_transpose.sv | 50 +++++
 rtl/btu_top.sv | 57 +++++
 tb/tb_btu_top.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btu_pkg.sv
// Shared sizes, transaction structs and mode decode for the bit-transpose unit.
package btu_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int NUM_WORDS  = 32;
  localparam int MAX_OUTPUT = 32;

  typedef struct packed {
    logic [4:0]                                n;
    logic [NUM_WORDS-1:0][DATA_WIDTH-1:0]      data;
  } btu_input_t;

  typedef struct packed {
    logic [6:0]                                num_rows;
    logic [MAX_OUTPUT-1:0][DATA_WIDTH-1:0]     rows;
  } btu_output_t;

  typedef enum logic [1:0] {
    MODE_NONE = 2'd0,
    MODE_BYTE = 2'd1,
    MODE_HALF = 2'd2
  } btu_mode_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } btu_state_t;

  // n=1..8 packs four values per word, n=9..16 packs two; anything else is empty.
  function automatic btu_mode_t btu_mode(input logic [4:0] n);
    if (n >= 5'd1 && n <= 5'd8) begin
      return MODE_BYTE;
    end else if (n >= 5'd9 && n <= 5'd16) begin
      return MODE_HALF;
    end
    return MODE_NONE;
  endfunction

endpackage

// File: rtl/btu_transpose.sv
// Combinational bit-plane transpose: word c of the input becomes column c of every row.
module btu_transpose
  import btu_pkg::*;
(
  input  logic [4:0]                            n,
  input  logic [NUM_WORDS-1:0][DATA_WIDTH-1:0]  data,
  output logic [6:0]                            num_rows,
  output logic [MAX_OUTPUT-1:0][DATA_WIDTH-1:0] rows
);

  btu_mode_t mode;

  assign mode = btu_mode(n);

  always_comb begin
    rows     = '0;
    num_rows = '0;
    case (mode)
      MODE_BYTE: begin
        num_rows = {n, 2'b00};
        // Slot k=0 is the most significant byte; its planes come first.
        for (int k = 0; k < 4; k++) begin
          for (int b = 0; b < 8; b++) begin
            if (b < int'(n)) begin
              for (int c = 0; c < NUM_WORDS; c++) begin
                rows[5'(k * int'(n) + b)][c] = data[c][8 * (3 - k) + b];
              end
            end
          end
        end
      end
      MODE_HALF: begin
        num_rows = {1'b0, n, 1'b0};
        for (int b = 0; b < 16; b++) begin
          if (b < int'(n)) begin
            for (int c = 0; c < NUM_WORDS; c++) begin
              rows[b][c]                 = data[c][16 + b];
              rows[5'(int'(n) + b)][c]   = data[c][b];
            end
          end
        end
      end
      default: begin
        rows     = '0;
        num_rows = '0;
      end
    endcase
  end

endmodule

// File: rtl/btu_top.sv
// Bit-transpose unit: one-deep output register with valid/ready on both sides.
module btu_top
  import btu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  output logic        ready_in,
  input  btu_input_t  data_in,
  input  logic        ready_out,
  output logic        valid_out,
  output btu_output_t data_out
);

  btu_state_t                            state;
  btu_state_t                            state_next;
  logic                                  accept;
  logic [6:0]                            num_rows_c;
  logic [MAX_OUTPUT-1:0][DATA_WIDTH-1:0] rows_c;

  btu_transpose u_transpose (
    .n        (data_in.n),
    .data     (data_in.data),
    .num_rows (num_rows_c),
    .rows     (rows_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // The register may be refilled in the same cycle it is drained.
  always_comb begin
    state_next = state;
    valid_out  = (state == ST_FULL);
    ready_in   = !valid_out || ready_out;
    accept     = valid_in && ready_in;
    if (accept) begin
      state_next = ST_FULL;
    end else if (ready_out) begin
      state_next = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
    end else if (accept) begin
      data_out <= '{num_rows: num_rows_c, rows: rows_c};
    end
  end

endmodule

// File: tb/tb_btu_top.sv
// Scoreboard bench for btu_top: directed cases, random traffic, backpressure and reset.
module tb_btu_top;
  import btu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic        ready_in;
  btu_input_t  data_in;
  logic        ready_out;
  logic        valid_out;
  btu_output_t data_out;

  btu_output_t exp_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          rand_ready = 1'b0;

  always #5 clk = ~clk;

  btu_top dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .data_in   (data_in),
    .ready_out (ready_out),
    .valid_out (valid_out),
    .data_out  (data_out)
  );

  // Reference: each output row r is derived directly from which value slot and bit it names.
  function automatic btu_output_t model(input btu_input_t d);
    btu_output_t o;
    int nn;
    int nr;
    int pos;
    o  = '0;
    nn = int'(d.n);
    if (nn >= 1 && nn <= 8)       nr = 4 * nn;
    else if (nn >= 9 && nn <= 16) nr = 2 * nn;
    else                          nr = 0;
    o.num_rows = 7'(nr);
    for (int r = 0; r < nr; r++) begin
      if (nn <= 8) pos = 8 * (3 - r / nn) + r % nn;
      else         pos = (r < nn) ? 16 + r : r - nn;
      for (int c = 0; c < NUM_WORDS; c++) o.rows[r][c] = d.data[c][pos];
    end
    return o;
  endfunction

  task automatic check_out(input string name, input btu_output_t got, input btu_output_t exp);
    int bad;
    checks++;
    if (got !== exp) begin
      errors++;
      bad = 0;
      for (int r = MAX_OUTPUT - 1; r >= 0; r--) if (got.rows[r] !== exp.rows[r]) bad = r;
      $display("FAIL %s: got num_rows=%0d row%0d=%h, required num_rows=%0d row%0d=%h",
               name, got.num_rows, bad, got.rows[bad], exp.num_rows, bad, exp.rows[bad]);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b, required %b", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && valid_out && ready_out) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got num_rows=%0d, required no output", data_out.num_rows);
      end else begin
        check_out("scoreboard", data_out, exp_q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      ready_out = ($urandom_range(3) != 0);
    end
  end

  task automatic send(input btu_input_t d, input btu_output_t e);
    bit ok;
    ok       = 1'b0;
    valid_in = 1'b1;
    data_in  = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready_in) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got ready_in=0 for 200 cycles, required ready_in=1");
      valid_in = 1'b0;
      return;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending, required 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fill_words(output btu_input_t d, input logic [4:0] n, input logic [31:0] w);
    d   = '0;
    d.n = n;
    for (int c = 0; c < NUM_WORDS; c++) d.data[c] = w;
  endtask

  btu_input_t  d;
  btu_input_t  d_b;
  btu_output_t e;
  btu_output_t e_a;
  btu_output_t e_b;

  initial begin
    rst       = 1'b1;
    valid_in  = 1'b0;
    ready_out = 1'b0;
    data_in   = '0;
    #12;
    check_bit("reset_valid_out", valid_out, 1'b0);
    check_out("reset_data_out", data_out, '0);
    check_bit("reset_ready_in", ready_in, 1'b1);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    ready_out = 1'b1;

    // n=4, 0x09 in every byte
    fill_words(d, 5'd4, 32'h0909_0909);
    e = '0;
    e.num_rows = 7'd16;
    foreach (e.rows[r]) if (r < 16 && (r % 4 == 0 || r % 4 == 3)) e.rows[r] = 32'hFFFF_FFFF;
    send(d, e);

    // n=9, 0x01 in every byte
    fill_words(d, 5'd9, 32'h0101_0101);
    e = '0;
    e.num_rows = 7'd18;
    e.rows[0]  = 32'hFFFF_FFFF;
    e.rows[8]  = 32'hFFFF_FFFF;
    e.rows[9]  = 32'hFFFF_FFFF;
    e.rows[17] = 32'hFFFF_FFFF;
    send(d, e);

    // n=1, alternating leftmost / rightmost byte
    d = '0;
    d.n = 5'd1;
    for (int c = 0; c < NUM_WORDS; c++) d.data[c] = (c % 2 == 1) ? 32'h0100_0000 : 32'h0000_0001;
    e = '0;
    e.num_rows = 7'd4;
    e.rows[0]  = 32'hAAAA_AAAA;
    e.rows[3]  = 32'h5555_5555;
    send(d, e);

    // n=16, one-hot walking word
    d = '0;
    d.n = 5'd16;
    for (int c = 0; c < NUM_WORDS; c++) d.data[c] = 32'h1 << c;
    e = '0;
    e.num_rows = 7'd32;
    for (int b = 0; b < 16; b++) begin
      e.rows[b]      = 32'h1 << (16 + b);
      e.rows[16 + b] = 32'h1 << b;
    end
    send(d, e);
    drain();

    rand_ready = 1'b1;
    for (int t = 0; t < 300; t++) begin
      d = '0;
      d.n = ($urandom_range(9) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(1, 16));
      for (int c = 0; c < NUM_WORDS; c++) d.data[c] = $urandom();
      send(d, model(d));
      repeat ($urandom_range(2)) @(posedge clk);
      #1;
    end
    drain();
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    ready_out = 1'b0;
    @(posedge clk);
    #1;

    // Backpressure: result held for 5 cycles
    d = '0;
    d.n = 5'($urandom_range(1, 16));
    for (int c = 0; c < NUM_WORDS; c++) d.data[c] = $urandom();
    e_a = model(d);
    send(d, e_a);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_bit("stall_ready_in", ready_in, 1'b0);
      check_bit("stall_valid_out", valid_out, 1'b1);
      check_out("stall_data_out", data_out, e_a);
    end
    @(posedge clk);
    #1;
    ready_out = 1'b1;
    d_b = '0;
    d_b.n = 5'd8;
    for (int c = 0; c < NUM_WORDS; c++) d_b.data[c] = $urandom();
    e_b = model(d_b);
    send(d_b, e_b);
    check_bit("b2b_valid_out", valid_out, 1'b1);
    check_out("b2b_data_out", data_out, e_b);
    @(negedge clk);
    @(posedge clk);
    #1;
    check_bit("drained_valid_out", valid_out, 1'b0);

    // Reset during a stall discards the held result
    ready_out = 1'b0;
    d = '0;
    d.n = 5'd12;
    for (int c = 0; c < NUM_WORDS; c++) d.data[c] = $urandom();
    send(d, model(d));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_bit("midreset_valid_out", valid_out, 1'b0);
    check_out("midreset_data_out", data_out, '0);
    check_bit("midreset_ready_in", ready_in, 1'b1);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    ready_out = 1'b1;

    // Out-of-range n gives an empty result
    d = '0;
    for (int c = 0; c < NUM_WORDS; c++) d.data[c] = $urandom();
    d.n = 5'd0;
    send(d, '0);
    d.n = 5'd20;
    send(d, '0);
    d.n = 5'd17;
    send(d, '0);
    drain();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_queue: got %0d pending, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
